video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter VIDEO_X_BITWIDTH, default 11, the width of the horizontal counter and pixX.
REQ-002 The block SHALL have parameter VIDEO_Y_BITWIDTH, default 10, the width of the vertical counter and pixY.
REQ-003 The block SHALL have parameters H_ACTIVE 1280, H_FP 110, H_SYNC 40 and H_BP 220, the horizontal segment lengths in pixel clocks.
REQ-004 The block SHALL have parameters V_ACTIVE 720, V_FP 5, V_SYNC 5 and V_BP 20, the vertical segment lengths in lines.
REQ-005 The block SHALL have parameters HS_POL 1 and VS_POL 1, the sync polarities (1 = active-high).
REQ-006 The ports SHALL be, in order:
- I_clk_pixel  in  1  pixel clock; all logic rising-edge.
- I_reset_n  in  1  synchronous, active-low reset.
- pixX  out  VIDEO_X_BITWIDTH  current horizontal count, 0..H_TOTAL-1.
- pixY  out  VIDEO_Y_BITWIDTH  current vertical count, 0..V_TOTAL-1.
- screenWidth  out  VIDEO_X_BITWIDTH  constant H_ACTIVE.
- screenHeight  out  VIDEO_Y_BITWIDTH  constant V_ACTIVE.
- I_rgb  in  24  pixel colour from the pixel generator, valid one clock after pixX/pixY.
- O_rgb  out  24  aligned output colour, {R,G,B}.
- O_de  out  1  data enable, aligned with O_rgb.
- O_hsync  out  1  horizontal sync, aligned with O_rgb.
- O_vsync  out  1  vertical sync, aligned with O_rgb.
- O_frame_start  out  1  one-clock pulse, aligned with O_rgb, on pixel (0,0).

Function
REQ-007 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (1650), and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (750).
REQ-008 The horizontal FSM SHALL have states H_ACT, H_FRONT, H_SYNCP and H_BACK, with transitions at pixX = H_ACTIVE-1, H_ACTIVE+H_FP-1, H_ACTIVE+H_FP+H_SYNC-1 and H_TOTAL-1 (H_BACK->H_ACT).
REQ-009 The vertical FSM SHALL have states V_ACT, V_FRONT, V_SYNCP and V_BACK, advancing only on the clock where pixX = H_TOTAL-1, with boundaries analogous to REQ-008.
REQ-010 pixX SHALL increment every clock and wrap from H_TOTAL-1 to 0.
REQ-011 pixY SHALL increment on each pixX wrap and wrap from V_TOTAL-1 to 0 on the same clock that pixX wraps.
REQ-012 The internal active signal for cycle t SHALL be (pixX < H_ACTIVE) && (pixY < V_ACTIVE); hsync is active in H_SYNCP and vsync is active in V_SYNCP (whole lines).
REQ-013 Latency: all of O_rgb, O_de, O_hsync, O_vsync and O_frame_start SHALL reflect counter cycle t at clock t+2.
REQ-014 O_rgb SHALL be registered as I_rgb when the one-stage-delayed active signal is 1, else 24'd0.
REQ-015 Sync outputs SHALL apply the configured polarity: output = state XOR (POL==0).
REQ-016 Counter width overflow is not permitted: parameters with H_TOTAL > 2^VIDEO_X_BITWIDTH (or the vertical equivalent) are illegal and SHALL be flagged by an elaboration-time check.

Reset
REQ-017 While I_reset_n = 0 at a clock edge, the block SHALL set pixX=0, pixY=0, FSMs=H_ACT/V_ACT, O_rgb=0, O_de=0, O_frame_start=0, O_hsync=O_vsync=inactive level, and clear both pipeline stages.
REQ-018 A reset asserted mid-frame SHALL take effect on the next edge; the first cycle after release SHALL be counter (0,0), and O_frame_start SHALL pulse 2 clocks later.

Structure
REQ-019 The timing defaults and the derived H_TOTAL/V_TOTAL SHALL live in a shared package video_timing_pkg, also used by the HDMI encoder wrapper.
REQ-020 The block SHALL contain one sub-module, sync_delay_line, a parameterised N-stage register for de, hsync, vsync and frame_start, cleared by reset.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Hold reset for 5 clocks -> all outputs 0 / inactive; 1st post-release clock pixX=0,pixY=0; O_frame_start=1 at release+2.
- Free-run one line -> O_hsync high for exactly 40 clocks, starting when the delayed pixX=1390; O_de high 1280 clocks per active line.
- Free-run one frame -> O_vsync high for 5×1650 clocks starting at line 725; pixY wraps 749->0 together with pixX 1649->0; O_frame_start once per 1,237,500 clocks.
- Drive I_rgb=24'hFF00FF constant -> O_rgb=FF00FF only while O_de=1, else 0; first active O_rgb coincides with O_frame_start.
- Drive I_rgb={8'd0,pixX_d1,...} tagged pattern -> O_rgb tag matches the pixel coordinates 2 clocks earlier (alignment check).
- Assert reset at pixX=700,pixY=300 for 1 clock -> counters restart at (0,0); no partial hsync pulse is emitted.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared 720p60 timing defaults, derived totals and raster FSM state types
package video_timing_pkg;
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;
    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int SYNC_PIPE_STAGES = 2;
    typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_t;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: N-stage shift register for timing flags, cleared by synchronous reset
module sync_delay_line
    import video_timing_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = SYNC_PIPE_STAGES
) (
    input  logic             I_clk_pixel,
    input  logic             I_reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] pipe [STAGES];
    always_ff @(posedge I_clk_pixel) begin
        if (!I_reset_n) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign q = pipe[STAGES-1];
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters with H/V sync FSMs; colour, DE and syncs
// all leave the block two clocks after the counter cycle they describe.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int VIDEO_X_BITWIDTH = 11,
    parameter int VIDEO_Y_BITWIDTH = 10,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic                        I_clk_pixel,
    input  logic                        I_reset_n,
    output logic [VIDEO_X_BITWIDTH-1:0] pixX,
    output logic [VIDEO_Y_BITWIDTH-1:0] pixY,
    output logic [VIDEO_X_BITWIDTH-1:0] screenWidth,
    output logic [VIDEO_Y_BITWIDTH-1:0] screenHeight,
    input  logic [23:0]                 I_rgb,
    output logic [23:0]                 O_rgb,
    output logic                        O_de,
    output logic                        O_hsync,
    output logic                        O_vsync,
    output logic                        O_frame_start
);
    localparam int h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [VIDEO_X_BITWIDTH-1:0] h_active_x = VIDEO_X_BITWIDTH'(H_ACTIVE);
    localparam logic [VIDEO_X_BITWIDTH-1:0] h_act_end  = VIDEO_X_BITWIDTH'(H_ACTIVE - 1);
    localparam logic [VIDEO_X_BITWIDTH-1:0] h_fp_end   = VIDEO_X_BITWIDTH'(H_ACTIVE + H_FP - 1);
    localparam logic [VIDEO_X_BITWIDTH-1:0] h_sync_end = VIDEO_X_BITWIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VIDEO_X_BITWIDTH-1:0] h_last     = VIDEO_X_BITWIDTH'(h_total - 1);
    localparam logic [VIDEO_Y_BITWIDTH-1:0] v_active_y = VIDEO_Y_BITWIDTH'(V_ACTIVE);
    localparam logic [VIDEO_Y_BITWIDTH-1:0] v_act_end  = VIDEO_Y_BITWIDTH'(V_ACTIVE - 1);
    localparam logic [VIDEO_Y_BITWIDTH-1:0] v_fp_end   = VIDEO_Y_BITWIDTH'(V_ACTIVE + V_FP - 1);
    localparam logic [VIDEO_Y_BITWIDTH-1:0] v_sync_end = VIDEO_Y_BITWIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VIDEO_Y_BITWIDTH-1:0] v_last     = VIDEO_Y_BITWIDTH'(v_total - 1);

    generate
        if (h_total > 2**VIDEO_X_BITWIDTH) begin : g_x_overflow
            $error("video_timing_gen: H total does not fit in VIDEO_X_BITWIDTH");
        end
        if (v_total > 2**VIDEO_Y_BITWIDTH) begin : g_y_overflow
            $error("video_timing_gen: V total does not fit in VIDEO_Y_BITWIDTH");
        end
    endgenerate

    h_state_t   h_state;
    v_state_t   v_state;
    logic       h_end, v_end, active_d1;
    logic [3:0] flags, flags_d2;

    assign h_end = (pixX == h_last);
    assign v_end = (pixY == v_last);

    // Vertical FSM only moves on the last pixel of a line, so sync covers whole lines
    always_ff @(posedge I_clk_pixel) begin
        if (!I_reset_n) begin
            pixX    <= '0;
            pixY    <= '0;
            h_state <= H_ACT;
            v_state <= V_ACT;
        end else begin
            pixX <= h_end ? '0 : pixX + 1'b1;
            if (h_end) pixY <= v_end ? '0 : pixY + 1'b1;
            case (h_state)
                H_ACT:   if (pixX == h_act_end)  h_state <= H_FRONT;
                H_FRONT: if (pixX == h_fp_end)   h_state <= H_SYNCP;
                H_SYNCP: if (pixX == h_sync_end) h_state <= H_BACK;
                default: if (h_end)              h_state <= H_ACT;
            endcase
            if (h_end)
                case (v_state)
                    V_ACT:   if (pixY == v_act_end)  v_state <= V_FRONT;
                    V_FRONT: if (pixY == v_fp_end)   v_state <= V_SYNCP;
                    V_SYNCP: if (pixY == v_sync_end) v_state <= V_BACK;
                    default: if (v_end)              v_state <= V_ACT;
                endcase
        end
    end

    assign flags = {(pixX < h_active_x) && (pixY < v_active_y), h_state == H_SYNCP,
                    v_state == V_SYNCP, (pixX == '0) && (pixY == '0)};

    sync_delay_line #(.WIDTH(4), .STAGES(SYNC_PIPE_STAGES)) u_sync_dly (
        .I_clk_pixel (I_clk_pixel),
        .I_reset_n   (I_reset_n),
        .d           (flags),
        .q           (flags_d2)
    );

    // Colour arrives one clock after the counters, so gate it with the once-delayed active flag
    always_ff @(posedge I_clk_pixel) begin
        active_d1 <= I_reset_n && flags[3];
        O_rgb     <= (I_reset_n && active_d1) ? I_rgb : 24'd0;
    end

    assign O_de          = flags_d2[3];
    assign O_hsync       = flags_d2[2] ^ (HS_POL == 1'b0);
    assign O_vsync       = flags_d2[1] ^ (VS_POL == 1'b0);
    assign O_frame_start = flags_d2[0];
    assign screenWidth   = h_active_x;
    assign screenHeight  = v_active_y;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: default 720p instance for line-level checks, plus a scaled-down
// instance (28x13 raster, active-low vsync) small enough to run whole frames and a mid-frame reset.
module tb_video_timing_gen;
    localparam int SH_ACT = 16, SH_FP = 4, SH_SYNC = 3, SH_BP = 5, SH_TOT = 28;
    localparam int SV_ACT = 6,  SV_FP = 2, SV_SYNC = 2, SV_BP = 3, SV_TOT = 13;
    localparam int S_FRAME = SH_TOT * SV_TOT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_def, rst_n_sml;
    logic [23:0] rgb_def, rgb_sml, d_rgb, s_rgb;
    logic [10:0] d_x, d_w;
    logic [9:0]  d_y, d_h;
    logic [4:0]  s_x, s_w, psx;
    logic [3:0]  s_y, s_h, psy;
    logic        d_de, d_hs, d_vs, d_fs, s_de, s_hs, s_vs, s_fs, d_hs_prev;

    int n_checks = 0, n_fail = 0;
    int mx, my, x1, y1, v1, x2, y2, v2, k, kd, last_fs, fs_cnt;
    int hs_cnt, de_cnt, vs_cnt, hs_start, d_px1, d_px2;

    video_timing_gen u_def (
        .I_clk_pixel(clk), .I_reset_n(rst_n_def), .pixX(d_x), .pixY(d_y),
        .screenWidth(d_w), .screenHeight(d_h), .I_rgb(rgb_def), .O_rgb(d_rgb),
        .O_de(d_de), .O_hsync(d_hs), .O_vsync(d_vs), .O_frame_start(d_fs)
    );

    video_timing_gen #(
        .VIDEO_X_BITWIDTH(5), .VIDEO_Y_BITWIDTH(4),
        .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_sml (
        .I_clk_pixel(clk), .I_reset_n(rst_n_sml), .pixX(s_x), .pixY(s_y),
        .screenWidth(s_w), .screenHeight(s_h), .I_rgb(rgb_sml), .O_rgb(s_rgb),
        .O_de(s_de), .O_hsync(s_hs), .O_vsync(s_vs), .O_frame_start(s_fs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: update the reference raster for both instances, compare at the falling edge
    task automatic tick();
        logic rs, rd;
        int ex_de, ex_hs, ex_vs, ex_fs, ex_rgb, dp, dxx, dyy, def_de;
        rs = rst_n_sml;
        rd = rst_n_def;
        @(negedge clk);
        if (!rs) begin
            mx = 0; my = 0; v1 = 0; v2 = 0; k = 0; last_fs = -1;
        end else begin
            v2 = v1; x2 = x1; y2 = y1;
            v1 = 1;  x1 = mx; y1 = my;
            if (mx == SH_TOT - 1) begin
                mx = 0;
                my = (my == SV_TOT - 1) ? 0 : my + 1;
            end else mx++;
            k++;
        end
        ex_de  = (v2 == 1 && x2 < SH_ACT && y2 < SV_ACT) ? 1 : 0;
        ex_hs  = (v2 == 1 && x2 >= SH_ACT + SH_FP && x2 < SH_ACT + SH_FP + SH_SYNC) ? 1 : 0;
        ex_vs  = (v2 == 1 && y2 >= SV_ACT + SV_FP && y2 < SV_ACT + SV_FP + SV_SYNC) ? 0 : 1;
        ex_fs  = (v2 == 1 && x2 == 0 && y2 == 0) ? 1 : 0;
        ex_rgb = (ex_de == 1) ? x2 * 256 + y2 : 0;
        check("s_pixX", 32'(s_x), mx);
        check("s_pixY", 32'(s_y), my);
        check("s_de", 32'(s_de), ex_de);
        check("s_hsync", 32'(s_hs), ex_hs);
        check("s_vsync", 32'(s_vs), ex_vs);
        check("s_frame_start", 32'(s_fs), ex_fs);
        check("s_rgb_tag", 32'(s_rgb), ex_rgb);
        if (s_fs) begin
            if (last_fs >= 0) check("s_frame_period", k - last_fs, S_FRAME);
            last_fs = k;
            fs_cnt++;
        end
        rgb_sml = {8'd0, 3'd0, psx, 4'd0, psy};
        psx = s_x;
        psy = s_y;
        kd = rd ? kd + 1 : 0;
        dp = kd - 2;
        dxx = dp % 1650;
        dyy = dp / 1650;
        def_de = (kd >= 2 && dxx < 1280 && dyy < 720) ? 1 : 0;
        check("d_rgb", 32'(d_rgb), (def_de == 1) ? 32'hFF00FF : 32'h0);
        if (kd == 1649) begin
            check("d_line_end_x", 32'(d_x), 1649);
            check("d_line_end_y", 32'(d_y), 0);
        end
        if (kd == 1650) begin
            check("d_wrap_x", 32'(d_x), 0);
            check("d_wrap_y", 32'(d_y), 1);
        end
        if (d_hs) hs_cnt++;
        if (d_hs && !d_hs_prev) hs_start = d_px2;
        if (d_de && kd <= 1651) de_cnt++;
        if (d_vs) vs_cnt++;
        d_hs_prev = d_hs;
        d_px2 = d_px1;
        d_px1 = 32'(d_x);
    endtask

    initial begin
        int hs_mid;
        bit found;
        rst_n_def = 1'b0; rst_n_sml = 1'b0;
        rgb_def = 24'hFF00FF; rgb_sml = 24'd0;
        psx = '0; psy = '0;
        mx = 0; my = 0; x1 = 0; y1 = 0; v1 = 0; x2 = 0; y2 = 0; v2 = 0;
        k = 0; kd = 0; last_fs = -1; fs_cnt = 0;
        hs_cnt = 0; de_cnt = 0; vs_cnt = 0; hs_start = -1; d_px1 = 0; d_px2 = 0;
        d_hs_prev = 1'b0;
        repeat (5) tick();
        check("rst_d_pixX", 32'(d_x), 0);
        check("rst_d_pixY", 32'(d_y), 0);
        check("rst_d_de", 32'(d_de), 0);
        check("rst_d_hsync", 32'(d_hs), 0);
        check("rst_d_vsync", 32'(d_vs), 0);
        check("rst_d_fs", 32'(d_fs), 0);
        check("rst_d_rgb", 32'(d_rgb), 0);
        check("d_width", 32'(d_w), 1280);
        check("d_height", 32'(d_h), 720);
        check("s_width", 32'(s_w), SH_ACT);
        check("s_height", 32'(s_h), SV_ACT);
        check("rst_s_vsync_idle_high", 32'(s_vs), 1);
        rst_n_def = 1'b1; rst_n_sml = 1'b1;
        check("rel_d_pixX", 32'(d_x), 0);
        check("rel_d_pixY", 32'(d_y), 0);
        tick();
        check("rel1_d_pixX", 32'(d_x), 1);
        check("rel1_d_fs", 32'(d_fs), 0);
        tick();
        check("rel2_d_fs", 32'(d_fs), 1);
        check("rel2_d_rgb_first", 32'(d_rgb), 32'hFF00FF);
        repeat (1700) tick();
        check("d_hs_width", hs_cnt, 40);
        check("d_hs_start_x", hs_start, 1390);
        check("d_de_line0", de_cnt, 1280);
        check("d_vs_quiet_line0", vs_cnt, 0);
        check("s_fs_count", fs_cnt, 5);
        found = 1'b0;
        for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
            tick();
            if (s_x == 5'd10 && s_y == 4'd4) found = 1'b1;
        end
        check("mid_reset_reached", 32'(found), 1);
        rst_n_sml = 1'b0;
        tick();
        rst_n_sml = 1'b1;
        check("mid_rst_pixX", 32'(s_x), 0);
        check("mid_rst_pixY", 32'(s_y), 0);
        hs_mid = 0;
        repeat (SH_TOT) begin
            tick();
            if (s_hs) hs_mid++;
        end
        check("mid_rst_hs_first_line", hs_mid, SH_SYNC);
        repeat (2 * SH_TOT) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
